// File: rtl/led_pattern_seq.sv
// LED flash sequencer. Debounced KEY buttons set the flash period and run/pause.
// The sequencer cycles the GREEN, RED, BOTH and ALT display phases.
module led_pattern_seq #(
    parameter int LED_WIDTH         = 8,
    parameter int TICK_BASE         = 12500000,
    parameter int STEPS_MIN         = 1,
    parameter int STEPS_MAX         = 8,
    parameter int STEPS_RESET       = 2,
    parameter int FLASHES_PER_PHASE = 6,
    parameter int DEBOUNCE_CYCLES   = 500000
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    input  logic [3:0]           KEY,
    output logic [LED_WIDTH-1:0] LEDG,
    output logic [LED_WIDTH-1:0] LEDR,
    output logic [1:0]           PHASE,
    output logic [3:0]           STEPS,
    output logic                 RUNNING
);

    localparam int TICK_SPAN = STEPS_MAX * TICK_BASE;
    localparam int CNT_W     = (TICK_SPAN > 1) ? $clog2(TICK_SPAN) : 1;
    localparam int DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FL_W      = (FLASHES_PER_PHASE > 1) ? $clog2(FLASHES_PER_PHASE) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLASHES_PER_PHASE - 1);
    localparam logic [3:0]      S_MIN   = 4'(STEPS_MIN);
    localparam logic [3:0]      S_MAX   = 4'(STEPS_MAX);
    localparam logic [3:0]      S_RST   = 4'(STEPS_RESET);

    localparam logic [1:0] PH_GREEN = 2'd0;
    localparam logic [1:0] PH_RED   = 2'd1;
    localparam logic [1:0] PH_BOTH  = 2'd2;
    localparam logic [1:0] PH_ALT   = 2'd3;

    logic [3:0]            sync1_q, sync2_q;
    logic [3:0]            deb_q, deb_d;
    logic [3:0][DB_W-1:0]  dbCnt_q, dbCnt_d;
    logic [3:0]            relEvt;
    logic [3:0]            steps_q, steps_d;
    logic                  running_q, running_d;
    logic [CNT_W-1:0]      tickCnt_q, tickCnt_d, termCnt;
    logic [FL_W-1:0]       flash_q, flash_d;
    logic [1:0]            phase_q, phase_d;
    logic [LED_WIDTH-1:0]  ledg_q, ledg_d, ledr_q, ledr_d;
    logic                  periodAct, tick, flashOn;

    // A debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        deb_d   = deb_q;
        dbCnt_d = '0;
        relEvt  = '0;
        for (int k = 0; k < 4; k++) begin
            if (sync2_q[k] != deb_q[k]) begin
                if (dbCnt_q[k] == DB_LAST) begin
                    deb_d[k]  = sync2_q[k];
                    relEvt[k] = sync2_q[k];
                end else begin
                    dbCnt_d[k] = dbCnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign periodAct = |relEvt[2:0];
    assign termCnt   = CNT_W'(32'(steps_q) * 32'(TICK_BASE) - 32'd1);
    assign tick      = running_q && !periodAct && (tickCnt_q == termCnt);
    assign flashOn   = ~flash_q[0];

    always_comb begin
        steps_d = steps_q;
        if (relEvt[2]) begin
            steps_d = S_RST;
        end else if (relEvt[0]) begin
            if (steps_q < S_MAX) steps_d = steps_q + 4'd1;
        end else if (relEvt[1]) begin
            if (steps_q > S_MIN) steps_d = steps_q - 4'd1;
        end

        running_d = running_q ^ relEvt[3];

        tickCnt_d = tickCnt_q;
        if (periodAct || tick) begin
            tickCnt_d = '0;
        end else if (running_q) begin
            tickCnt_d = tickCnt_q + 1'b1;
        end

        ledg_d  = ledg_q;
        ledr_d  = ledr_q;
        flash_d = flash_q;
        phase_d = phase_q;
        if (tick) begin
            case (phase_q)
                PH_GREEN: begin
                    ledg_d = flashOn ? '1 : '0;
                    ledr_d = '0;
                end
                PH_RED: begin
                    ledg_d = '0;
                    ledr_d = flashOn ? '1 : '0;
                end
                PH_BOTH: begin
                    ledg_d = flashOn ? '1 : '0;
                    ledr_d = flashOn ? '1 : '0;
                end
                PH_ALT: begin
                    ledg_d = flashOn ? '1 : '0;
                    ledr_d = flashOn ? '0 : '1;
                end
                default: begin
                    ledg_d = '0;
                    ledr_d = '0;
                end
            endcase
            if (flash_q == FL_LAST) begin
                flash_d = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                flash_d = flash_q + 1'b1;
            end
        end
    end

    // Synchronisers reset to the released level so reset never fabricates a key event
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            deb_q     <= '1;
            dbCnt_q   <= '0;
            steps_q   <= S_RST;
            running_q <= 1'b1;
            tickCnt_q <= '0;
            flash_q   <= '0;
            phase_q   <= PH_GREEN;
            ledg_q    <= '0;
            ledr_q    <= '0;
        end else begin
            sync1_q   <= KEY;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            dbCnt_q   <= dbCnt_d;
            steps_q   <= steps_d;
            running_q <= running_d;
            tickCnt_q <= tickCnt_d;
            flash_q   <= flash_d;
            phase_q   <= phase_d;
            ledg_q    <= ledg_d;
            ledr_q    <= ledr_d;
        end
    end

    assign LEDG    = ledg_q;
    assign LEDR    = ledr_q;
    assign PHASE   = phase_q;
    assign STEPS   = steps_q;
    assign RUNNING = running_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: vector table, directed corner cases and random key traffic.
// A per-cycle reference model is built from tick indices and sample windows.
module tb_led_pattern_seq;

    localparam int TB_BASE = 4;
    localparam int DEB     = 3;
    localparam int FPP     = 6;
    localparam int SMIN    = 1;
    localparam int SMAX    = 8;
    localparam int SRST    = 2;
    localparam logic [7:0] WIN_MASK = 8'((1 << DEB) - 1);

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic [3:0] KEY;
    logic [7:0] LEDG, LEDR;
    logic [1:0] PHASE;
    logic [3:0] STEPS;
    logic       RUNNING;

    int checks = 0;
    int errors = 0;

    led_pattern_seq #(
        .LED_WIDTH(8), .TICK_BASE(TB_BASE), .STEPS_MIN(SMIN), .STEPS_MAX(SMAX),
        .STEPS_RESET(SRST), .FLASHES_PER_PHASE(FPP), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .KEY(KEY), .LEDG(LEDG), .LEDR(LEDR),
        .PHASE(PHASE), .STEPS(STEPS), .RUNNING(RUNNING)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [3:0] mRaw1, mRaw2, mDeb;
    logic [7:0] mHist [4];
    int         mSteps, mElapsed, mTickIdx;
    logic       mRunning;
    logic [7:0] mLedg, mLedr;

    typedef struct {
        logic [3:0] pressMask;
        int         hold;
        int         expSteps;
        logic       expRunning;
    } vec_t;

    vec_t vecs [19];

    task automatic modelReset();
        mRaw1 = 4'hF;
        mRaw2 = 4'hF;
        mDeb  = 4'hF;
        for (int k = 0; k < 4; k++) mHist[k] = 8'hFF;
        mSteps   = SRST;
        mElapsed = 0;
        mTickIdx = 0;
        mRunning = 1'b1;
        mLedg    = 8'h00;
        mLedr    = 8'h00;
    endtask

    // Key level accepted once the last DEB synchronised samples all disagree with it
    task automatic stepModel();
        logic [3:0] rel;
        logic       syncNow, act, tickNow, on;
        int         oldSteps, f;
        logic       oldRun;
        if (!RESET_N) begin
            modelReset();
            return;
        end
        rel = '0;
        for (int k = 0; k < 4; k++) begin
            syncNow  = mRaw2[k];
            mRaw2[k] = mRaw1[k];
            mRaw1[k] = KEY[k];
            mHist[k] = {mHist[k][6:0], syncNow};
            if (!mDeb[k] && ((mHist[k] & WIN_MASK) == WIN_MASK)) begin
                mDeb[k] = 1'b1;
                rel[k]  = 1'b1;
            end else if (mDeb[k] && ((mHist[k] & WIN_MASK) == 8'h00)) begin
                mDeb[k] = 1'b0;
            end
        end
        oldSteps = mSteps;
        oldRun   = mRunning;
        act      = 1'b0;
        tickNow  = 1'b0;
        if (rel[2]) begin
            mSteps = SRST;
            act = 1'b1;
        end else if (rel[0]) begin
            if (mSteps < SMAX) mSteps++;
            act = 1'b1;
        end else if (rel[1]) begin
            if (mSteps > SMIN) mSteps--;
            act = 1'b1;
        end
        if (act) begin
            mElapsed = 0;
        end else if (oldRun) begin
            mElapsed++;
            if (mElapsed == oldSteps * TB_BASE) begin
                tickNow  = 1'b1;
                mElapsed = 0;
            end
        end
        if (tickNow) begin
            f  = mTickIdx % FPP;
            on = ((f % 2) == 0);
            case (mTickIdx / FPP)
                0:       begin mLedg = on ? 8'hFF : 8'h00; mLedr = 8'h00; end
                1:       begin mLedg = 8'h00; mLedr = on ? 8'hFF : 8'h00; end
                2:       begin mLedg = on ? 8'hFF : 8'h00; mLedr = on ? 8'hFF : 8'h00; end
                default: begin mLedg = on ? 8'hFF : 8'h00; mLedr = on ? 8'h00 : 8'hFF; end
            endcase
            mTickIdx = (mTickIdx + 1) % (4 * FPP);
        end
        if (rel[3]) mRunning = !mRunning;
    endtask

    task automatic checkOutput(input string tag);
        logic [22:0] got, exp;
        got = {LEDG, LEDR, PHASE, STEPS, RUNNING};
        exp = {mLedg, mLedr, 2'(mTickIdx / FPP), 4'(mSteps), mRunning};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got ledg=%h ledr=%h phase=%0d steps=%0d run=%b, expected ledg=%h ledr=%h phase=%0d steps=%0d run=%b",
                     tag, $time, got[22:15], got[14:7], got[6:5], got[4:1], got[0],
                     exp[22:15], exp[14:7], exp[6:5], exp[4:1], exp[0]);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] key, input int cycles);
        KEY = key;
        for (int c = 0; c < cycles; c++) begin
            @(posedge CLOCK_50);
            stepModel();
            #1;
            checkOutput("model");
        end
    endtask

    task automatic releaseKey(input logic [3:0] mask, input int hold);
        applyStimulus(~mask, hold);
        applyStimulus(4'hF, 8);
    endtask

    task automatic assertReset();
        RESET_N = 1'b0;
        modelReset();
        #1;
        checkOutput("async reset");
        checkValue("reset LEDG", int'(LEDG), 0);
        checkValue("reset LEDR", int'(LEDR), 0);
        checkValue("reset PHASE", int'(PHASE), 0);
        checkValue("reset STEPS", int'(STEPS), SRST);
        checkValue("reset RUNNING", int'(RUNNING), 1);
        applyStimulus(KEY, 2);
        RESET_N = 1'b1;
    endtask

    // Every tick changes at least one LED bank, so LED changes mark tick times
    task automatic measureSpacing(input string name, input int expected);
        logic [15:0] prev;
        int first, spacing;
        first   = -1;
        spacing = -1;
        prev    = {LEDG, LEDR};
        for (int c = 1; c <= 100 && spacing < 0; c++) begin
            applyStimulus(4'hF, 1);
            if ({LEDG, LEDR} != prev) begin
                if (first < 0) first = c;
                else spacing = c - first;
            end
            prev = {LEDG, LEDR};
        end
        if (spacing < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: no two ticks within 100 cycles, expected spacing %0d", name, expected);
        end else begin
            checkValue(name, spacing, expected);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] m;
        int r;

        vecs[0]  = '{4'b0001, 10, 3, 1'b1};
        vecs[1]  = '{4'b0001,  6, 4, 1'b1};
        vecs[2]  = '{4'b0001,  4, 5, 1'b1};
        vecs[3]  = '{4'b0001,  7, 6, 1'b1};
        vecs[4]  = '{4'b0001,  5, 7, 1'b1};
        vecs[5]  = '{4'b0001, 12, 8, 1'b1};
        vecs[6]  = '{4'b0001,  6, 8, 1'b1};
        vecs[7]  = '{4'b0001,  9, 8, 1'b1};
        vecs[8]  = '{4'b0010,  6, 7, 1'b1};
        vecs[9]  = '{4'b0100,  6, 2, 1'b1};
        vecs[10] = '{4'b0010,  5, 1, 1'b1};
        vecs[11] = '{4'b0010,  8, 1, 1'b1};
        vecs[12] = '{4'b0001,  6, 2, 1'b1};
        vecs[13] = '{4'b0101,  6, 2, 1'b1};
        vecs[14] = '{4'b0011,  6, 3, 1'b1};
        vecs[15] = '{4'b1000,  6, 3, 1'b0};
        vecs[16] = '{4'b0001,  6, 4, 1'b0};
        vecs[17] = '{4'b1000,  6, 4, 1'b1};
        vecs[18] = '{4'b0110,  6, 2, 1'b1};

        RESET_N = 1'b1;
        KEY     = 4'hF;
        modelReset();
        #2;
        assertReset();

        // Free run: first tick on the 8th edge, phase wraps after 24 ticks
        applyStimulus(4'hF, 7);
        checkValue("pre-first-tick LEDG", int'(LEDG), 0);
        applyStimulus(4'hF, 1);
        checkValue("first tick LEDG", int'(LEDG), 8'hFF);
        checkValue("first tick LEDR", int'(LEDR), 0);
        applyStimulus(4'hF, 176);
        checkValue("tick23 PHASE", int'(PHASE), 3);
        applyStimulus(4'hF, 8);
        checkValue("tick24 PHASE", int'(PHASE), 0);
        checkValue("tick24 LEDG", int'(LEDG), 0);
        checkValue("tick24 LEDR", int'(LEDR), 8'hFF);
        applyStimulus(4'hF, 192);

        $display("[TB] key vector table");
        for (int i = 0; i < 19; i++) begin
            releaseKey(vecs[i].pressMask, vecs[i].hold);
            checkValue($sformatf("vec%0d STEPS", i), int'(STEPS), vecs[i].expSteps);
            checkValue($sformatf("vec%0d RUNNING", i), int'(RUNNING), int'(vecs[i].expRunning));
        end

        releaseKey(4'b0010, 10);
        checkValue("steps at minimum", int'(STEPS), 1);
        measureSpacing("tick spacing steps=1", 4);
        releaseKey(4'b0100, 6);
        releaseKey(4'b0001, 6);
        checkValue("steps after default+slow", int'(STEPS), 3);
        measureSpacing("tick spacing steps=3", 12);

        for (int b = 0; b < 5; b++) begin
            applyStimulus(4'hE, 2);
            applyStimulus(4'hF, 1);
        end
        applyStimulus(4'hF, 10);
        checkValue("bounce ignored", int'(STEPS), 3);

        releaseKey(4'b1000, 6);
        checkValue("paused", int'(RUNNING), 0);
        applyStimulus(4'hF, 100);
        checkValue("still paused", int'(RUNNING), 0);
        releaseKey(4'b1000, 6);
        checkValue("resumed", int'(RUNNING), 1);

        applyStimulus(4'hF, 13);
        assertReset();

        // Key debounced as pressed, held through reset, released right after
        applyStimulus(4'hE, 20);
        assertReset();
        applyStimulus(4'hE, 1);
        applyStimulus(4'hF, 10);
        checkValue("no event after reset", int'(STEPS), 2);

        applyStimulus(4'hE, 20);
        assertReset();
        applyStimulus(4'hE, 20);
        applyStimulus(4'hF, 10);
        checkValue("event after re-press", int'(STEPS), 3);

        $display("[TB] random key traffic");
        for (int s = 0; s < 80; s++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                assertReset();
            end else if (r < 4) begin
                m = 4'(1 << $urandom_range(0, 3));
                for (int b = 0; b < $urandom_range(1, 4); b++) begin
                    applyStimulus(~m, $urandom_range(1, 2));
                    applyStimulus(4'hF, 1);
                end
            end else if (r < 12) begin
                m = 4'($urandom_range(1, 15));
                releaseKey(m, $urandom_range(3, 12));
            end else begin
                applyStimulus(4'hF, $urandom_range(1, 30));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
